// File: rtl/bikers_collision_dispatch_pkg.sv
// Shared bikers definitions: bike counts, hit-type encoding, dispatch FSM states and a
// saturating population count used for the per-frame hit summary.
package bikers_collision_dispatch_pkg;

  localparam int unsigned ENEMY_BIKES_COUNT = 8;
  localparam int unsigned PLAYER_IDX        = ENEMY_BIKES_COUNT;
  localparam int unsigned IDX_W             = $clog2(ENEMY_BIKES_COUNT);
  localparam int unsigned CNT_W             = 4;

  // Hit type carried with each event.
  localparam logic HIT_PLAYER   = 1'b0;
  localparam logic HIT_OBSTACLE = 1'b1;

  // Dispatch FSM encoding.
  typedef logic [1:0] state_t;
  localparam state_t StIdle    = 2'd0;
  localparam state_t StCollect = 2'd1;
  localparam state_t StDrain   = 2'd2;

  // Number of set bits, clamped to the largest value CNT_W bits can hold.
  function automatic logic [CNT_W-1:0] sat_popcount(input logic [ENEMY_BIKES_COUNT-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(ENEMY_BIKES_COUNT); i++) begin
      if (v[i]) n++;
    end
    if (n > (2 ** CNT_W) - 1) n = (2 ** CNT_W) - 1;
    return n[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/bikers_collision_dispatch_if.sv
// Hit-event stream from the collision dispatcher to the game controller (valid/ready).
interface bikers_collision_dispatch_if;
  import bikers_collision_dispatch_pkg::*;

  logic             hitValid;
  logic             hitReady;
  logic [IDX_W-1:0] hitIndex;
  logic             hitType;

  // Event producer.
  modport master (
    output hitValid,
    output hitIndex,
    output hitType,
    input  hitReady
  );

  // Event consumer.
  modport slave (
    input  hitValid,
    input  hitIndex,
    input  hitType,
    output hitReady
  );

endinterface

// File: rtl/bikers_priority_pick.sv
// Combinational lowest-set-bit finder over a {obstacle, player} pending vector.
// Bits [N-1:0] are player hits, bits [2N-1:N] obstacle hits; bit 0 has highest priority.
module bikers_priority_pick
  import bikers_collision_dispatch_pkg::*;
#(
  parameter int unsigned N  = ENEMY_BIKES_COUNT,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [2*N-1:0] pend_i,
  output logic           found_o,
  output logic [IW-1:0]  idx_o,
  output logic           type_o,
  output logic [2*N-1:0] grant_o
);

  // Scan from the top down so the lowest set bit is the one left standing.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    type_o  = HIT_PLAYER;
    grant_o = '0;
    for (int k = 2 * int'(N) - 1; k >= 0; k--) begin
      if (pend_i[k]) begin
        found_o    = 1'b1;
        grant_o    = '0;
        grant_o[k] = 1'b1;
        if (k >= int'(N)) begin
          idx_o  = IW'(k - int'(N));
          type_o = HIT_OBSTACLE;
        end else begin
          idx_o  = IW'(k);
          type_o = HIT_PLAYER;
        end
      end
    end
  end

endmodule

// File: rtl/bikers_collision_dispatch.sv
// Per-pixel collision detector for the bikers scene. Enemy/player and enemy/obstacle
// overlaps are accumulated over a frame, snapshotted at startOfFrame and drained to the
// game controller one indexed event per cycle.
module bikers_collision_dispatch
  import bikers_collision_dispatch_pkg::*;
(
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         startOfFrame,
  input  logic [ENEMY_BIKES_COUNT:0]   drawingRequest,
  input  logic                         obstacleDR,
  bikers_collision_dispatch_if.master  hit,
  output logic                         playerCrash,
  output logic [CNT_W-1:0]             frameHitCount,
  output logic                         overrun
);

  localparam int unsigned N = ENEMY_BIKES_COUNT;

  state_t           state_q, state_d;
  logic [N-1:0]     acc_player_q, acc_player_d;
  logic [N-1:0]     acc_obst_q, acc_obst_d;
  logic             acc_crash_q, acc_crash_d;
  logic [2*N-1:0]   pend_q, pend_d;
  logic             crash_q, crash_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [N-1:0]     enemy_dr;
  logic             player_dr;
  logic [N-1:0]     det_player, det_obst;
  logic             det_crash;
  logic [N-1:0]     snap_player, snap_obst;
  logic             snap_crash;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_type;
  logic [2*N-1:0]   pick_grant;
  logic             take;
  logic [2*N-1:0]   pend_drained;

  // Current-pixel overlap terms; enemy-enemy overlap is deliberately not detected.
  always_comb begin
    enemy_dr   = drawingRequest[N-1:0];
    player_dr  = drawingRequest[PLAYER_IDX];
    det_player = enemy_dr & {N{player_dr}};
    det_obst   = enemy_dr & {N{obstacleDR}};
    det_crash  = player_dr & obstacleDR;
    // A pixel coincident with startOfFrame still belongs to the ending frame.
    snap_player = acc_player_q | det_player;
    snap_obst   = acc_obst_q | det_obst;
    snap_crash  = acc_crash_q | det_crash;
  end

  bikers_priority_pick #(
    .N  (N),
    .IW (IDX_W)
  ) u_pick (
    .pend_i  (pend_q),
    .found_o (pick_found),
    .idx_o   (pick_idx),
    .type_o  (pick_type),
    .grant_o (pick_grant)
  );

  // Pending vector after this cycle's handshake, if any.
  always_comb begin
    take         = pick_found & hit.hitReady;
    pend_drained = take ? (pend_q & ~pick_grant) : pend_q;
  end

  // Next-state: accumulation, frame snapshot, drain and overrun detection.
  always_comb begin
    state_d      = state_q;
    acc_player_d = acc_player_q;
    acc_obst_d   = acc_obst_q;
    acc_crash_d  = acc_crash_q;
    pend_d       = pend_drained;
    crash_d      = 1'b0;
    overrun_d    = 1'b0;
    count_d      = count_q;

    case (state_q)
      StIdle: begin
        // Nothing before the first frame boundary is trusted.
        acc_player_d = '0;
        acc_obst_d   = '0;
        acc_crash_d  = 1'b0;
        if (startOfFrame) state_d = StCollect;
      end

      StCollect, StDrain: begin
        if (startOfFrame) begin
          acc_player_d = '0;
          acc_obst_d   = '0;
          acc_crash_d  = 1'b0;
          pend_d       = {snap_obst, snap_player};
          crash_d      = snap_crash;
          count_d      = sat_popcount(snap_player | snap_obst);
          // An event accepted on this very edge is not counted as lost.
          overrun_d    = |pend_drained;
          state_d      = (|{snap_obst, snap_player}) ? StDrain : StCollect;
        end else begin
          acc_player_d = acc_player_q | det_player;
          acc_obst_d   = acc_obst_q | det_obst;
          acc_crash_d  = acc_crash_q | det_crash;
          if (state_q == StDrain && pend_drained == '0) state_d = StCollect;
        end
      end

      default: begin
        state_d = StIdle;
        pend_d  = '0;
      end
    endcase
  end

  // State registers; reset drops any partially drained snapshot.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      acc_player_q <= '0;
      acc_obst_q   <= '0;
      acc_crash_q  <= 1'b0;
      pend_q       <= '0;
      crash_q      <= 1'b0;
      overrun_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      acc_player_q <= acc_player_d;
      acc_obst_q   <= acc_obst_d;
      acc_crash_q  <= acc_crash_d;
      pend_q       <= pend_d;
      crash_q      <= crash_d;
      overrun_q    <= overrun_d;
      count_q      <= count_d;
    end
  end

  // Event stream presents the highest-priority pending bit straight from pend_q.
  always_comb begin
    hit.hitValid  = pick_found;
    hit.hitIndex  = pick_idx;
    hit.hitType   = pick_type;
    playerCrash   = crash_q;
    overrun       = overrun_q;
    frameHitCount = count_q;
  end

endmodule

// File: tb/tb_bikers_collision_dispatch.sv
// Scoreboard bench for bikers_collision_dispatch: expected events are queued when a frame
// boundary is driven and checked in order as the DUT hands them off.
module tb_bikers_collision_dispatch;
  import bikers_collision_dispatch_pkg::*;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             typ;
  } ev_t;

  logic                       clk = 1'b0;
  logic                       resetN;
  logic                       sof;
  logic [ENEMY_BIKES_COUNT:0] dr;
  logic                       obs;
  logic                       player_crash;
  logic [CNT_W-1:0]           frame_hit_count;
  logic                       overrun;

  bikers_collision_dispatch_if hit_if ();

  bikers_collision_dispatch dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (sof),
    .drawingRequest (dr),
    .obstacleDR     (obs),
    .hit            (hit_if),
    .playerCrash    (player_crash),
    .frameHitCount  (frame_hit_count),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  ev_t                             exp_q[$];
  int                              total = 0;
  int                              bad   = 0;
  logic                            in_frame;
  logic [ENEMY_BIKES_COUNT-1:0]    m_player, m_obst;
  logic                            m_crash;
  logic                            exp_crash, exp_overrun;
  int                              exp_count;

  task automatic check(input string tag, input int obs_v, input int exp_v);
    total++;
    if (obs_v != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel cycle; updates the frame model and, on a boundary, the scoreboard.
  task automatic pixel(input logic [ENEMY_BIKES_COUNT:0] d, input logic o, input logic s);
    logic [ENEMY_BIKES_COUNT-1:0] sp, so;
    logic sc;
    int keep, n;
    dr  = d;
    obs = o;
    sof = s;
    sp = m_player | (d[ENEMY_BIKES_COUNT-1:0] & {ENEMY_BIKES_COUNT{d[ENEMY_BIKES_COUNT]}});
    so = m_obst | (d[ENEMY_BIKES_COUNT-1:0] & {ENEMY_BIKES_COUNT{o}});
    sc = m_crash | (d[ENEMY_BIKES_COUNT] & o);
    if (s) begin
      if (in_frame) begin
        keep = (hit_if.hitReady && exp_q.size() > 0) ? 1 : 0;
        exp_overrun = (exp_q.size() > keep);
        while (exp_q.size() > keep) void'(exp_q.pop_back());
        for (int i = 0; i < int'(ENEMY_BIKES_COUNT); i++)
          if (sp[i]) exp_q.push_back('{idx: IDX_W'(i), typ: HIT_PLAYER});
        for (int i = 0; i < int'(ENEMY_BIKES_COUNT); i++)
          if (so[i]) exp_q.push_back('{idx: IDX_W'(i), typ: HIT_OBSTACLE});
        exp_crash = sc;
        n = 0;
        for (int i = 0; i < int'(ENEMY_BIKES_COUNT); i++) if (sp[i] | so[i]) n++;
        exp_count = (n > 15) ? 15 : n;
      end else begin
        exp_overrun = 1'b0;
        exp_crash   = 1'b0;
      end
      in_frame = 1'b1;
      m_player = '0;
      m_obst   = '0;
      m_crash  = 1'b0;
    end else if (in_frame) begin
      m_player = sp;
      m_obst   = so;
      m_crash  = sc;
    end
    tick();
    if (s) begin
      check("snap_crash", player_crash, exp_crash);
      check("snap_overrun", overrun, exp_overrun);
      check("snap_count", frame_hit_count, exp_count);
      check("snap_valid", hit_if.hitValid, exp_q.size() > 0);
    end
    dr  = '0;
    obs = 1'b0;
    sof = 1'b0;
  endtask

  task automatic model_clear();
    exp_q.delete();
    in_frame  = 1'b0;
    m_player  = '0;
    m_obst    = '0;
    m_crash   = 1'b0;
    exp_count = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, hit_if.hitValid, 0);
    check({tag, "_index"}, hit_if.hitIndex, 0);
    check({tag, "_type"}, hit_if.hitType, 0);
    check({tag, "_crash"}, player_crash, 0);
    check({tag, "_count"}, frame_hit_count, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) tick();
    check("drain_done", exp_q.size(), 0);
    tick();
    check("drain_idle", hit_if.hitValid, 0);
  endtask

  // Scoreboard consumer: every accepted event must be the next expected one.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (resetN && hit_if.hitValid && hit_if.hitReady) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("ev_index", hit_if.hitIndex, e.idx);
        check("ev_type", hit_if.hitType, e.typ);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetN          = 1'b0;
    sof             = 1'b0;
    dr              = '0;
    obs             = 1'b0;
    hit_if.hitReady = 1'b0;
    exp_crash       = 1'b0;
    exp_overrun     = 1'b0;
    model_clear();
    #1;
    check_all_zero("reset");
    tick();
    tick();
    resetN = 1'b1;
    tick();

    // Empty first frame boundary.
    hit_if.hitReady = 1'b1;
    pixel('0, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    check("collect_state", dut.state_q, StCollect);
    tick();
    check("empty_crash", player_crash, 0);

    // Bike 3 over the player for five pixels.
    for (int i = 0; i < 5; i++) pixel(9'h108, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    check("single_valid", hit_if.hitValid, 1);
    check("single_index", hit_if.hitIndex, 3);
    check("single_type", hit_if.hitType, HIT_PLAYER);
    tick();
    check("single_done", hit_if.hitValid, 0);

    // Stalled drain with player and obstacle hits.
    hit_if.hitReady = 1'b0;
    pixel(9'h122, 1'b0, 1'b0);
    pixel(9'h122, 1'b0, 1'b0);
    pixel(9'h002, 1'b1, 1'b0);
    pixel(9'h002, 1'b1, 1'b0);
    pixel('0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", hit_if.hitValid, 1);
      check("stall_index", hit_if.hitIndex, 1);
      check("stall_type", hit_if.hitType, HIT_PLAYER);
      tick();
    end
    hit_if.hitReady = 1'b1;
    wait_drain(10);
    check("drain_state", dut.state_q, StCollect);

    // Player/obstacle overlap only on the boundary pixel.
    pixel('0, 1'b0, 1'b0);
    pixel(9'h100, 1'b1, 1'b1);
    tick();
    check("crash_pulse_end", player_crash, 0);
    for (int i = 0; i < 3; i++) pixel('0, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);

    // Undrained events lost at the next boundary.
    hit_if.hitReady = 1'b0;
    for (int i = 0; i < 3; i++) pixel(9'h115, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) pixel('0, 1'b0, 1'b0);
    check("pre_overrun_valid", hit_if.hitValid, 1);
    pixel('0, 1'b0, 1'b1);
    tick();
    check("overrun_pulse_end", overrun, 0);
    check("overrun_valid", hit_if.hitValid, 0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 2; i++) pixel(9'h107, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    tick();
    #3;
    resetN = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("async_reset_state", dut.state_q, StIdle);
    model_clear();
    tick();
    resetN          = 1'b1;
    hit_if.hitReady = 1'b1;
    for (int i = 0; i < 2; i++) pixel(9'h101, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    check("post_reset_first", hit_if.hitValid, 0);
    for (int i = 0; i < 2; i++) pixel('0, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    check("post_reset_second", hit_if.hitValid, 0);
    pixel(9'h140, 1'b0, 1'b0);
    pixel('0, 1'b0, 1'b1);
    wait_drain(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bikers_collision_dispatch.md
Name: bikers_collision_dispatch

Overview:
- Per-pixel inverse of the bikers priority mux. It watches the per-bike drawing-request vector together with the obstacle drawing request, and detects which enemy bike overlaps the player bike or an obstacle in the same pixel.
- Collisions are accumulated over one frame and snapshotted at startOfFrame. The snapshot is then drained as a stream of indexed hit events to the game controller over a valid/ready handshake.
- Sits between the bikers drawing logic and the game-state controller.

Parameters:
- ENEMY_BIKES_COUNT, 8: number of enemy bikes. drawingRequest bits [ENEMY_BIKES_COUNT-1:0] are enemies; bit [ENEMY_BIKES_COUNT] is the player.
- IDX_W, $clog2(ENEMY_BIKES_COUNT): width of hitIndex. Value is 3 at the default.

Ports:
- clk  in  1  pixel clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  single-cycle pulse marking frame boundary.
- drawingRequest  in  ENEMY_BIKES_COUNT+1  per-bike inside-rectangle flags for the current pixel.
- obstacleDR  in  1  obstacle drawing request for the current pixel.
- hitReady  in  1  controller accepts the current event.
- hitValid  out  1  an event is presented.
- hitIndex  out  IDX_W  enemy bike index of the event.
- hitType  out  1  0 = enemy hit player, 1 = enemy hit obstacle.
- playerCrash  out  1  one-cycle pulse: player overlapped an obstacle during the previous frame.
- frameHitCount  out  4  number of enemies with any hit in the last snapshot, saturating at 15.
- overrun  out  1  one-cycle pulse: undrained events were discarded.

Behaviour:
- Reset values (async, resetN=0): all outputs 0; accumulators, pending registers and count cleared; state = IDLE.
- Detection (every cycle, registered):
  - accPlayer[i] |= drawingRequest[i] & drawingRequest[ENEMY_BIKES_COUNT].
  - accObst[i] |= drawingRequest[i] & obstacleDR.
  - accCrash |= drawingRequest[ENEMY_BIKES_COUNT] & obstacleDR.
  - Enemy-enemy overlap is ignored.
- Frame boundary (startOfFrame=1):
  - Pending vectors are loaded with acc OR the current-cycle detection terms. A pixel coincident with startOfFrame belongs to the ending frame.
  - Accumulators are cleared to 0 in the same edge.
- State machine:
  - IDLE: wait for the first startOfFrame after reset; discard everything before it; go to COLLECT.
  - COLLECT: accumulate. On startOfFrame, take the snapshot. If the snapshot is nonzero, go to DRAIN; otherwise stay in COLLECT.
  - DRAIN: accumulation of the new frame continues in parallel. When pending is empty, go to COLLECT.
- Snapshot outputs, registered one cycle after the startOfFrame edge:
  - playerCrash pulses for 1 cycle if the snapshot crash bit is set.
  - frameHitCount = popcount(pendPlayer | pendObst), saturated at 15, held until the next snapshot.
- Drain order:
  - All pendPlayer bits first, lowest index first (same priority as the mux: index 0 highest), then pendObst bits, lowest index first.
  - hitValid is asserted the cycle after the snapshot edge and presents the highest-priority pending bit.
  - On a cycle with hitValid & hitReady, that bit is cleared and the next event appears in the following cycle. Throughput is 1 event/cycle.
  - While hitReady=0, hitValid, hitIndex and hitType hold stable.
- Overrun: startOfFrame while pending is nonzero.
  - The remaining pending bits are discarded and overrun pulses 1 cycle.
  - The new snapshot replaces pending, and state stays or enters DRAIN per the new snapshot.
  - If hitValid & hitReady occur in that same cycle, the handshake completes and that event is not counted as lost.
- Reset mid-drain: everything is cleared immediately and state returns to IDLE. No partial event survives.
- Latency: collision pixel -> earliest hitValid = end of frame + 1 cycle.

Decomposition:
- Shared bikers package holds:
  - ENEMY_BIKES_COUNT.
  - PLAYER_IDX = ENEMY_BIKES_COUNT.
  - Hit-type constants HIT_PLAYER=1'b0 and HIT_OBSTACLE=1'b1.
  - The state enum {IDLE, COLLECT, DRAIN}.
- One sub-module: bikers_priority_pick.
  - Combinational lowest-set-bit finder over a 2×ENEMY_BIKES_COUNT pending vector.
  - Returns found flag, index and type.
  - Reusable by other arbitration blocks.

Test Plan:
- Reset, then startOfFrame with no drawing activity -> state COLLECT, hitValid=0, frameHitCount=0, playerCrash never pulses.
- Frame where DR bits 8 and 3 are both high for 5 pixels; startOfFrame; hitReady=1 -> exactly one event {hitIndex=3, hitType=0} in the cycle after the edge; frameHitCount=1.
- Frame with player overlapping bikes 5 and 1, and bike 1 overlapping an obstacle; hitReady held 0 for 4 cycles then 1 -> hitValid stable on {1,0} while stalled, then order {1,0}, {5,0}, {1,1}; frameHitCount=2.
- Player overlaps the obstacle only on the same cycle as startOfFrame -> playerCrash pulses 1 cycle after that edge; the next frame's snapshot has crash=0.
- Frame with bikes 0, 2 and 4 hitting the player; hitReady=0 across the next startOfFrame -> overrun pulses once; pending replaced by the new frame's snapshot (all zero), hitValid drops to 0.
- resetN asserted low mid-DRAIN with 3 events pending -> all outputs 0 immediately (asynchronously); after release, no events until the second frame boundary.
